// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - FIFO push/pull and status bundle; FIFO_CTRL_ERR_FLAGS_EN adds o_ovf/o_udf
interface fifo_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              i_wr_en;
    logic [WIDTH-1:0]  i_D;
    logic              i_rd_en;
    logic [WIDTH-1:0]  o_Q;
    logic              o_valid;
    logic              o_full;
    logic              o_empty;
    logic              o_afull;
    logic [ADDR_W:0]   o_count;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic              o_ovf;
    logic              o_udf;

    modport master (
        output i_wr_en, i_D, i_rd_en,
        input  o_Q, o_valid, o_full, o_empty, o_afull, o_count, o_ovf, o_udf
    );
    modport slave (
        input  i_wr_en, i_D, i_rd_en,
        output o_Q, o_valid, o_full, o_empty, o_afull, o_count, o_ovf, o_udf
    );
`else
    modport master (
        output i_wr_en, i_D, i_rd_en,
        input  o_Q, o_valid, o_full, o_empty, o_afull, o_count
    );
    modport slave (
        input  i_wr_en, i_D, i_rd_en,
        output o_Q, o_valid, o_full, o_empty, o_afull, o_count
    );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - single-clock FIFO with registered read data and status
// Optional sticky overflow/underflow flags enabled by FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    fifo_ctrl_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    logic [ADDR_W:0]  r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;

    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [ADDR_W:0]  w_wr_ptr_nxt;
    logic [ADDR_W:0]  w_rd_ptr_nxt;
    logic [ADDR_W:0]  w_count_nxt;

    // A write into a full FIFO is legal only when a read frees a slot on the same edge.
    assign w_rd_ok = bus.i_rd_en & ~r_empty;
    assign w_wr_ok = bus.i_wr_en & (~r_full | w_rd_ok);

    assign w_wr_ptr_nxt = w_wr_ok ? r_wr_ptr + ONE : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_ok ? r_rd_ptr + ONE : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + ONE;
            2'b01:   w_count_nxt = r_count - ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr_ok) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.i_D;
        end
    end

    // Status flags are computed from next-state pointers so they match the state after the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_q      <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= w_rd_ok;
            if (w_rd_ok) begin
                r_q <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full   <= (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                        (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
            r_afull  <= (w_count_nxt >= AF_L);
        end
    end

    assign bus.o_Q     = r_q;
    assign bus.o_valid = r_valid;
    assign bus.o_full  = r_full;
    assign bus.o_empty = r_empty;
    assign bus.o_afull = r_afull;
    assign bus.o_count = r_count;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.i_wr_en && r_full && !w_rd_ok) r_ovf <= 1'b1;
            if (bus.i_rd_en && r_empty)            r_udf <= 1'b1;
        end
    end

    assign bus.o_ovf = r_ovf;
    assign bus.o_udf = r_udf;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl (WIDTH=8, DEPTH=4, AF_LEVEL=3)
module tb_fifo_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fifo_ctrl_if #(.WIDTH(8), .DEPTH(4)) bus ();

    fifo_ctrl #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Apply one cycle of requests, then sample 1ns after the edge.
    task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
        bus.i_wr_en = wr;
        bus.i_D     = d;
        bus.i_rd_en = rd;
        @(posedge clk);
        #1;
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.i_wr_en = 1'b1;
        bus.i_rd_en = 1'b1;
        bus.i_D     = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
        checks++; if (bus.o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.o_count); end
        checks++; if (bus.o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.o_empty); end
        checks++; if (bus.o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.o_full); end
        checks++; if (bus.o_afull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", bus.o_afull); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_Q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", bus.o_Q); end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        checks++; if (bus.o_ovf !== 1'b0 || bus.o_udf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.o_ovf, bus.o_udf); end
`endif
    endtask

    task automatic test_fill;
        logic [7:0] data [4];
        data = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, data[i], 1'b0);
            checks++; if (bus.o_count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.o_count, i + 1); end
            checks++; if (bus.o_afull !== (i >= 2)) begin failures++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, bus.o_afull, i >= 2); end
            checks++; if (bus.o_full !== (i == 3)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus.o_full, i == 3); end
            checks++; if (bus.o_empty !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, bus.o_empty); end
            checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL fill_valid[%0d] got=%b exp=0", i, bus.o_valid); end
        end
    endtask

    task automatic test_drain;
        logic [7:0] data [4];
        data = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, bus.o_valid); end
            checks++; if (bus.o_Q !== data[i]) begin failures++; $display("FAIL drain_q[%0d] got=%h exp=%h", i, bus.o_Q, data[i]); end
            checks++; if (bus.o_count !== 3'(3 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.o_count, 3 - i); end
            checks++; if (bus.o_empty !== (i == 3)) begin failures++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, bus.o_empty, i == 3); end
            checks++; if (bus.o_full !== 1'b0) begin failures++; $display("FAIL drain_full[%0d] got=%b exp=0", i, bus.o_full); end
        end
    endtask

    task automatic test_full_wr_rd;
        logic [7:0] data [4];
        data = '{8'h22, 8'h33, 8'h44, 8'h55};
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        checks++; if (bus.o_Q !== 8'h11 || bus.o_valid !== 1'b1) begin failures++; $display("FAIL fullrw_q got=%h/%b exp=11/1", bus.o_Q, bus.o_valid); end
        checks++; if (bus.o_count !== 3'd4 || bus.o_full !== 1'b1) begin failures++; $display("FAIL fullrw_count got=%0d/%b exp=4/1", bus.o_count, bus.o_full); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (bus.o_Q !== data[i]) begin failures++; $display("FAIL fullrw_drain_q[%0d] got=%h exp=%h", i, bus.o_Q, data[i]); end
        end
        checks++; if (bus.o_empty !== 1'b1) begin failures++; $display("FAIL fullrw_empty got=%b exp=1", bus.o_empty); end
    endtask

    task automatic test_wrap;
        cycle(1'b1, 8'hA0, 1'b0);
        cycle(1'b1, 8'hA1, 1'b0);
        for (int i = 2; i < 6; i++) begin
            cycle(1'b1, 8'(8'hA0 + i), 1'b0);
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (bus.o_Q !== 8'(8'hA0 + i - 2)) begin failures++; $display("FAIL wrap_q[%0d] got=%h exp=%h", i, bus.o_Q, 8'(8'hA0 + i - 2)); end
            checks++; if (bus.o_count !== 3'd2) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, bus.o_count); end
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_Q !== 8'hA4) begin failures++; $display("FAIL wrap_tail0 got=%h exp=a4", bus.o_Q); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_Q !== 8'hA5) begin failures++; $display("FAIL wrap_tail1 got=%h exp=a5", bus.o_Q); end
        checks++; if (bus.o_empty !== 1'b1 || bus.o_count !== 3'd0) begin failures++; $display("FAIL wrap_end got=%b/%0d exp=1/0", bus.o_empty, bus.o_count); end
    endtask

    task automatic test_illegal;
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL udf_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_Q !== 8'hA5) begin failures++; $display("FAIL udf_q got=%h exp=a5", bus.o_Q); end
        checks++; if (bus.o_count !== 3'd0 || bus.o_empty !== 1'b1) begin failures++; $display("FAIL udf_state got=%0d/%b exp=0/1", bus.o_count, bus.o_empty); end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        checks++; if (bus.o_udf !== 1'b1 || bus.o_ovf !== 1'b0) begin failures++; $display("FAIL udf_flag got=%b/%b exp=1/0", bus.o_udf, bus.o_ovf); end
`endif
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0);
        cycle(1'b1, 8'hC0, 1'b0);
        checks++; if (bus.o_count !== 3'd4 || bus.o_full !== 1'b1) begin failures++; $display("FAIL ovf_count got=%0d/%b exp=4/1", bus.o_count, bus.o_full); end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        checks++; if (bus.o_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.o_ovf); end
`endif
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (bus.o_Q !== 8'(8'hB0 + i)) begin failures++; $display("FAIL ovf_drain_q[%0d] got=%h exp=%h", i, bus.o_Q, 8'(8'hB0 + i)); end
        end
        cycle(1'b1, 8'hD0, 1'b1);
        checks++; if (bus.o_valid !== 1'b0 || bus.o_Q !== 8'hB3) begin failures++; $display("FAIL empty_wr_rd got=%b/%h exp=0/b3", bus.o_valid, bus.o_Q); end
        checks++; if (bus.o_count !== 3'd1 || bus.o_empty !== 1'b0) begin failures++; $display("FAIL empty_wr_rd_count got=%0d/%b exp=1/0", bus.o_count, bus.o_empty); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_Q !== 8'hD0 || bus.o_valid !== 1'b1) begin failures++; $display("FAIL empty_wr_rd_data got=%h/%b exp=d0/1", bus.o_Q, bus.o_valid); end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 8'hE0, 1'b0);
        cycle(1'b1, 8'hE1, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_count !== 3'd2 || bus.o_Q !== 8'hE0) begin failures++; $display("FAIL rstmid_pre got=%0d/%h exp=2/e0", bus.o_count, bus.o_Q); end
        rst = 1'b1;
        cycle(1'b1, 8'hF0, 1'b1);
        rst = 1'b0;
        checks++; if (bus.o_count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", bus.o_count); end
        checks++; if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_afull !== 1'b0) begin failures++; $display("FAIL rstmid_status got=%b%b%b exp=100", bus.o_empty, bus.o_full, bus.o_afull); end
        checks++; if (bus.o_Q !== 8'h00 || bus.o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_q got=%h/%b exp=00/0", bus.o_Q, bus.o_valid); end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        checks++; if (bus.o_ovf !== 1'b0 || bus.o_udf !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b exp=00", bus.o_ovf, bus.o_udf); end
`endif
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_Q !== 8'h5A || bus.o_empty !== 1'b1) begin failures++; $display("FAIL rstmid_after got=%h/%b exp=5a/1", bus.o_Q, bus.o_empty); end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        checks      = 0;
        failures    = 0;
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_D     = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_full_wr_rd();
        test_wrap();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
